// File: rtl/exec_multi_lane.sv
// exec_multi_lane: N-lane in-order execute stage (integer ALU per lane, FPU dispatch, shared signed divider).
// Latency: 1 cycle from commit edge to registered outputs; each divide lane adds XLEN+3 stall cycles.
// Backpressure: interlock freezes the output register; exec_stall (comb) holds upstream while divides are pending.
// Optional divider: define EXEC_DIV_EN; when undefined, e_type 8 acts as Nop and exec_stall is tied low.
module exec_multi_lane #(
  parameter int NLANES = 2,
  parameter int XLEN   = 32,
  parameter int ILEN   = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   interlock,
  input  logic [31:0]            pc,
  input  logic [NLANES*ILEN-1:0] inst,
  input  logic [NLANES*XLEN-1:0] srca,
  input  logic [NLANES*XLEN-1:0] srcb,
  input  logic [NLANES*4-1:0]    e_type,
  input  logic [NLANES*5-1:0]    rt,
  input  logic [NLANES-1:0]      rt_flag,
  output logic                   exec_stall,
  output logic [31:0]            pc_out,
  output logic [NLANES*ILEN-1:0] inst_out,
  output logic [NLANES*XLEN-1:0] tdata,
  output logic [NLANES*5-1:0]    rt_out,
  output logic [NLANES-1:0]      rt_flag_out,
  output logic [NLANES-1:0]      fpu_valid,
  output logic [NLANES*3-1:0]    fpu_op,
  output logic [NLANES*XLEN-1:0] fpu_srca,
  output logic [NLANES*XLEN-1:0] fpu_srcb,
  output logic [NLANES*5-1:0]    fpu_rt
);

  localparam int SHW = (XLEN > 1) ? $clog2(XLEN) : 1;
  // Nop instruction word: Nop opcode is 0 and all other fields are 0
  localparam logic [ILEN-1:0] NOP_INST = '0;

  logic [NLANES*XLEN-1:0] alu_res;
  logic [NLANES*XLEN-1:0] lane_res;
  logic [NLANES-1:0]      fpu_mask;
  logic [NLANES*3-1:0]    fpu_op_n;

`ifdef EXEC_DIV_EN
  localparam int CW = $clog2(XLEN + 1);
  localparam int LW = (NLANES > 1) ? $clog2(NLANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} div_state_t;

  div_state_t             state;
  logic [NLANES-1:0]      div_mask;
  logic [NLANES-1:0]      done_mask;
  logic [NLANES-1:0]      pend;
  logic [NLANES*XLEN-1:0] qreg;
  logic [LW-1:0]          lane_sel;
  logic [LW-1:0]          pend_lane;
  logic [XLEN-1:0]        op_a;
  logic [XLEN-1:0]        op_b;
  logic [XLEN-1:0]        dvd;     // dividend magnitude, shifted out as quotient bits shift in
  logic [XLEN-1:0]        dvs;     // divisor magnitude
  logic [XLEN:0]          rem;
  logic [XLEN+1:0]        rem_sh;
  logic                   ge;
  logic                   neg;
  logic [CW-1:0]          count;
  logic                   commit;
`endif

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] r;
    logic [3:0]      et;

    assign a  = srca[g*XLEN +: XLEN];
    assign b  = srcb[g*XLEN +: XLEN];
    assign et = e_type[g*4 +: 4];

    // single-cycle integer ALU; Nop, Div (when no divider) and FPU types pass srcb
    always_comb begin
      r = b;
      case (et)
        4'd1:    r = a + b;
        4'd2:    r = a - b;
        4'd3:    r = $unsigned($signed(a) >>> b[SHW-1:0]);
        4'd4:    r = a << b[SHW-1:0];
        4'd5:    r = a & b;
        4'd6:    r = a | b;
        4'd7:    r = a ^ b;
        default: r = b;
      endcase
    end

    assign alu_res[g*XLEN +: XLEN] = r;
    assign fpu_mask[g]             = (et >= 4'd9);
    assign fpu_op_n[g*3 +: 3]      = 3'(et - 4'd9);

`ifdef EXEC_DIV_EN
    assign div_mask[g]              = (et == 4'd8);
    assign lane_res[g*XLEN +: XLEN] = div_mask[g] ? qreg[g*XLEN +: XLEN] : r;
`else
    assign lane_res[g*XLEN +: XLEN] = r;
`endif
  end

`ifdef EXEC_DIV_EN
  assign pend       = div_mask & ~done_mask;
  assign exec_stall = |pend;
  assign commit     = ~interlock & ~exec_stall;
  assign op_a       = srca[lane_sel*XLEN +: XLEN];
  assign op_b       = srcb[lane_sel*XLEN +: XLEN];
  assign rem_sh     = {rem, dvd[XLEN-1]};
  assign ge         = rem_sh >= {2'b00, dvs};

  // lowest-numbered lane whose divide is still outstanding
  always_comb begin
    pend_lane = '0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (pend[i]) pend_lane = LW'(i);
    end
  end

  // shared divider: pick lane, load magnitudes, restoring shift-subtract, then post signed quotient
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      done_mask <= '0;
      qreg      <= '0;
      lane_sel  <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      neg       <= 1'b0;
      count     <= '0;
    end else begin
      if (commit) done_mask <= '0;
      case (state)
        S_IDLE: begin
          if (exec_stall) begin
            lane_sel <= pend_lane;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          dvd   <= op_a[XLEN-1] ? -op_a : op_a;
          dvs   <= op_b[XLEN-1] ? -op_b : op_b;
          // divide by zero keeps the all-ones magnitude unsigned, i.e. -1
          neg   <= (op_a[XLEN-1] ^ op_b[XLEN-1]) & (|op_b);
          rem   <= '0;
          count <= CW'(XLEN);
          state <= S_RUN;
        end
        S_RUN: begin
          rem   <= ge ? (XLEN+1)'(rem_sh - {2'b00, dvs}) : (XLEN+1)'(rem_sh);
          dvd   <= {dvd[XLEN-2:0], ge};
          count <= count - CW'(1);
          if (count == CW'(1)) state <= S_FIN;
        end
        S_FIN: begin
          qreg[lane_sel*XLEN +: XLEN] <= neg ? -dvd : dvd;
          done_mask[lane_sel]         <= 1'b1;
          state                       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign exec_stall = 1'b0;
`endif

  // output register: commit the bundle, insert a bubble while stalled, or hold under interlock
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_out      <= '0;
      inst_out    <= {NLANES{NOP_INST}};
      tdata       <= '0;
      rt_out      <= '0;
      rt_flag_out <= '0;
      fpu_valid   <= '0;
      fpu_op      <= '0;
      fpu_srca    <= '0;
      fpu_srcb    <= '0;
      fpu_rt      <= '0;
    end else if (!interlock) begin
      if (!exec_stall) begin
        pc_out      <= pc;
        inst_out    <= inst;
        tdata       <= lane_res;
        rt_out      <= rt;
        rt_flag_out <= rt_flag;
        fpu_valid   <= fpu_mask;
        fpu_op      <= fpu_op_n;
        fpu_srca    <= srca;
        fpu_srcb    <= srcb;
        fpu_rt      <= rt;
      end else begin
        inst_out    <= {NLANES{NOP_INST}};
        rt_flag_out <= '0;
        fpu_valid   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_exec_multi_lane.sv
// Bench for exec_multi_lane (NLANES=2, XLEN=32): scoreboard of committed bundles plus stall/hold/reset checks.
// Driver pushes the expected registered bundle when it presents inputs; the monitor pops on each commit edge.
// Divider cases are exercised when EXEC_DIV_EN is defined, otherwise Div must behave as Nop with no stall.
module tb_exec_multi_lane;

  localparam int NL = 2;
  localparam int XL = 32;
  localparam int IL = 32;

  logic              clk;
  logic              rstn;
  logic              interlock;
  logic [31:0]       pc;
  logic [NL*IL-1:0]  inst;
  logic [NL*XL-1:0]  srca;
  logic [NL*XL-1:0]  srcb;
  logic [NL*4-1:0]   e_type;
  logic [NL*5-1:0]   rt;
  logic [NL-1:0]     rt_flag;
  logic              exec_stall;
  logic [31:0]       pc_out;
  logic [NL*IL-1:0]  inst_out;
  logic [NL*XL-1:0]  tdata;
  logic [NL*5-1:0]   rt_out;
  logic [NL-1:0]     rt_flag_out;
  logic [NL-1:0]     fpu_valid;
  logic [NL*3-1:0]   fpu_op;
  logic [NL*XL-1:0]  fpu_srca;
  logic [NL*XL-1:0]  fpu_srcb;
  logic [NL*5-1:0]   fpu_rt;

  logic armed;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [31:0]      pc;
    logic [NL*IL-1:0] inst;
    logic [NL*XL-1:0] tdata;
    logic [NL*XL-1:0] tmask;
    logic [NL*5-1:0]  rt;
    logic [NL-1:0]    rtf;
    logic [NL-1:0]    fv;
    logic [NL*3-1:0]  fop;
    logic [NL*XL-1:0] fsa;
    logic [NL*XL-1:0] fsb;
  } exp_t;

  exp_t sb[$];

  exec_multi_lane #(.NLANES(NL), .XLEN(XL), .ILEN(IL)) dut (
    .clk(clk), .rstn(rstn), .interlock(interlock), .pc(pc), .inst(inst),
    .srca(srca), .srcb(srcb), .e_type(e_type), .rt(rt), .rt_flag(rt_flag),
    .exec_stall(exec_stall), .pc_out(pc_out), .inst_out(inst_out), .tdata(tdata),
    .rt_out(rt_out), .rt_flag_out(rt_flag_out), .fpu_valid(fpu_valid), .fpu_op(fpu_op),
    .fpu_srca(fpu_srca), .fpu_srcb(fpu_srcb), .fpu_rt(fpu_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: one commit edge per fire, outputs sampled on the following negedge
  initial begin
    logic fire_last;
    exp_t e;
    fire_last = 1'b0;
    forever begin
      @(negedge clk);
      if (fire_last) begin
        if (sb.size() == 0) begin
          check("unexpected_commit", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("pc_out", 64'(pc_out), 64'(e.pc));
          check("inst_out", inst_out, e.inst);
          check("tdata", tdata & e.tmask, e.tdata & e.tmask);
          check("rt_out", 64'(rt_out), 64'(e.rt));
          check("rt_flag_out", 64'(rt_flag_out), 64'(e.rtf));
          check("fpu_valid", 64'(fpu_valid), 64'(e.fv));
          for (int i = 0; i < NL; i++) begin
            if (e.fv[i]) begin
              check("fpu_op", 64'(fpu_op[i*3 +: 3]), 64'(e.fop[i*3 +: 3]));
              check("fpu_rt", 64'(fpu_rt[i*5 +: 5]), 64'(e.rt[i*5 +: 5]));
              check("fpu_srca", 64'(fpu_srca[i*XL +: XL]), 64'(e.fsa[i*XL +: XL]));
              check("fpu_srcb", 64'(fpu_srcb[i*XL +: XL]), 64'(e.fsb[i*XL +: XL]));
            end
          end
        end
      end
      fire_last = armed && rstn && !interlock && !exec_stall;
    end
  end

  // present one bundle (called at posedge+1) and follow it to its commit edge
  task automatic send(
    input  logic [31:0] p,
    input  logic [3:0]  e0, input logic [31:0] a0, input logic [31:0] b0,
    input  logic [3:0]  e1, input logic [31:0] a1, input logic [31:0] b1,
    input  logic [4:0]  r1, input logic [1:0] rf,
    input  logic [31:0] x0, input logic [31:0] x1,
    input  int il_lo, input int il_hi, input int rst_lo, input int rst_hi,
    output int stall_n, output int commit_c, output int bubbles, output int hold_bad);
    exp_t e;
    int   c;
    logic prev_stall;
    bit   done;
    pc      = p;
    inst    = {p ^ 32'h2222_0000, p ^ 32'h1111_0000};
    e_type  = {e1, e0};
    srca    = {a1, a0};
    srcb    = {b1, b0};
    rt      = {r1, 5'd3};
    rt_flag = rf;
    armed   = 1'b1;
    e.pc    = p;
    e.inst  = inst;
    e.tdata = {x1, x0};
    e.tmask = {(e1 >= 4'd9) ? 32'h0 : 32'hFFFF_FFFF, (e0 >= 4'd9) ? 32'h0 : 32'hFFFF_FFFF};
    e.rt    = {r1, 5'd3};
    e.rtf   = rf;
    e.fv    = {e1 >= 4'd9, e0 >= 4'd9};
    e.fop   = {3'(e1 - 4'd9), 3'(e0 - 4'd9)};
    e.fsa   = {a1, a0};
    e.fsb   = {b1, b0};
    sb.push_back(e);
    stall_n = 0; commit_c = -1; bubbles = 0; hold_bad = 0;
    prev_stall = 1'b0; c = 0; done = 1'b0;
    while (!done) begin
      interlock = (c >= il_lo) && (c <= il_hi);
      rstn      = !((c >= rst_lo) && (c <= rst_hi));
      @(negedge clk);
      if (prev_stall && rt_flag_out == '0 && fpu_valid == '0 && inst_out == '0) bubbles++;
      if (il_lo >= 0 && c > il_lo && c <= il_hi + 1 && rt_flag_out != '0) hold_bad++;
      if (rst_lo >= 0 && c == rst_lo + 1) begin
        check("midrst_rt_flag_out", 64'(rt_flag_out), 64'd0);
        check("midrst_pc_out", 64'(pc_out), 64'd0);
        check("midrst_fpu_valid", 64'(fpu_valid), 64'd0);
      end
      if (exec_stall && c > rst_hi) stall_n++;
      if (rstn && !interlock && !exec_stall) begin
        commit_c = c;
        done     = 1'b1;
      end
      prev_stall = exec_stall;
      if (!done && c >= 400) begin
        check("commit_timeout", 64'(c), 64'd0);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      c++;
    end
    interlock = 1'b0;
    rstn      = 1'b1;
    armed     = 1'b0;
  endtask

  initial begin
    int sn, cc, bb, hb;
    rstn = 1'b0; interlock = 1'b0; armed = 1'b0;
    pc = 32'h1234_5678; inst = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    srca = {32'h5, 32'h9}; srcb = {32'h6, 32'h7};
    e_type = {4'd11, 4'd1}; rt = 10'h3FF; rt_flag = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rt_flag_out", 64'(rt_flag_out), 64'd0);
    check("rst_fpu_valid", 64'(fpu_valid), 64'd0);
    check("rst_pc_out", 64'(pc_out), 64'd0);
    check("rst_inst_out", inst_out, 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_rt_out", 64'(rt_out), 64'd0);
    check("rst_exec_stall", 64'(exec_stall), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Add overflow wraps; Rshift uses only low 5 bits of srcb (0x21 -> 1)
    send(32'h100, 4'd1, 32'h7FFF_FFFF, 32'h1, 4'd3, 32'h8000_0000, 32'h21, 5'd9, 2'b11,
         32'h8000_0000, 32'hC000_0000, -1, -1, -1, -1, sn, cc, bb, hb);
    check("alu1_stall", 64'(sn), 64'd0);
    check("alu1_commit_cycle", 64'(cc), 64'd0);
    send(32'h104, 4'd2, 32'h5, 32'h9, 4'd4, 32'h1, 32'h24, 5'd10, 2'b01,
         32'hFFFF_FFFC, 32'h0000_0010, -1, -1, -1, -1, sn, cc, bb, hb);
    send(32'h108, 4'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd7, 32'hAAAA_5555, 32'hFFFF_0000, 5'd11, 2'b10,
         32'h00F0_1200, 32'h5555_5555, -1, -1, -1, -1, sn, cc, bb, hb);
    send(32'h10C, 4'd6, 32'h1200_0000, 32'h34, 4'd0, 32'h1, 32'hDEAD_BEEF, 5'd12, 2'b11,
         32'h1200_0034, 32'hDEAD_BEEF, -1, -1, -1, -1, sn, cc, bb, hb);
    // FPU dispatch on lane1: Fmul -> fpu_op 2, fpu_rt 7
    send(32'h110, 4'd1, 32'h1, 32'h2, 4'd11, 32'h4000_0000, 32'h4040_0000, 5'd7, 2'b11,
         32'h3, 32'h0, -1, -1, -1, -1, sn, cc, bb, hb);

`ifdef EXEC_DIV_EN
    // two divide lanes served back to back: 2 x 35 stall cycles, a bubble each cycle
    send(32'h200, 4'd8, 32'hFFFF_FFF9, 32'h2, 4'd8, 32'd100, 32'h0, 5'd13, 2'b11,
         32'hFFFF_FFFD, 32'hFFFF_FFFF, -1, -1, -1, -1, sn, cc, bb, hb);
    check("div2_stall", 64'(sn), 64'd70);
    check("div2_bubbles", 64'(bb), 64'd70);
    // most-negative / -1 stays most-negative
    send(32'h204, 4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 4'd1, 32'h3, 32'h4, 5'd14, 2'b11,
         32'h8000_0000, 32'h7, -1, -1, -1, -1, sn, cc, bb, hb);
    check("divovf_stall", 64'(sn), 64'd35);
    // interlock held across cycles 10..50: stall still ends at 35, commit waits for cycle 51
    send(32'h208, 4'd8, 32'd100, 32'd7, 4'd7, 32'hF0, 32'h0F, 5'd15, 2'b11,
         32'hE, 32'hFF, 10, 50, -1, -1, sn, cc, bb, hb);
    check("il_stall", 64'(sn), 64'd35);
    check("il_commit_cycle", 64'(cc), 64'd51);
    check("il_hold", 64'(hb), 64'd0);
    // reset at cycle 20 of a divide: full 35-cycle restart afterwards
    send(32'h20C, 4'd2, 32'd10, 32'd3, 4'd8, 32'hFFFF_FF9C, 32'd7, 5'd16, 2'b11,
         32'h7, 32'hFFFF_FFF2, -1, -1, 20, 21, sn, cc, bb, hb);
    check("rstdiv_stall", 64'(sn), 64'd35);
    check("rstdiv_commit_cycle", 64'(cc), 64'd57);
`else
    // without the divider, Div passes srcb through and never stalls
    send(32'h300, 4'd8, 32'd100, 32'd7, 4'd8, 32'd5, 32'h1234, 5'd17, 2'b11,
         32'h7, 32'h1234, -1, -1, -1, -1, sn, cc, bb, hb);
    check("nodiv_stall", 64'(sn), 64'd0);
    check("nodiv_commit_cycle", 64'(cc), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_multi_lane.md
Name: exec_multi_lane

Overview:
- Parametrised execute stage for an N-issue in-order pipeline; the successor to the fixed dual-lane execute stage.
- Sits between register read/forwarding and the writeback/FPU-result stage.
- Each lane runs a single-cycle integer ALU and dispatches float ops to the FPU pipes through per-lane request ports.
- A shared iterative signed divider serves integer divides, stalling upstream until every divide lane of the current bundle is done.

Parameters:
- NLANES, 2, issue width (number of lanes), 1..4.
- XLEN, 32, datapath width in bits.
- ILEN, 32, instruction width per lane.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- interlock  in  1  downstream hold; the output register does not update while 1.
- pc  in  32  bundle PC.
- inst  in  NLANES*ILEN  bundle instruction words; lane i at [i*ILEN +: ILEN].
- srca, srcb  in  NLANES*XLEN each  per-lane operands.
- e_type  in  NLANES*4  per-lane exec type.
- rt  in  NLANES*5  per-lane destination register.
- rt_flag  in  NLANES  per-lane writeback enable.
- exec_stall  out  1  combinational; 1 means upstream must hold the bundle.
- pc_out  out  32  registered PC.
- inst_out  out  NLANES*ILEN  registered instructions.
- tdata  out  NLANES*XLEN  integer result per lane.
- rt_out  out  NLANES*5  registered destination per lane.
- rt_flag_out  out  NLANES  registered writeback enable per lane.
- fpu_valid  out  NLANES  per-lane FPU request.
- fpu_op  out  NLANES*3  FPU op, equal to e_type-9.
- fpu_srca, fpu_srcb  out  NLANES*XLEN each  FPU operands.
- fpu_rt  out  NLANES*5  FPU destination.

Behaviour:
- e_type encoding:
  - 0 Nop: result = srcb.
  - 1 Add, 2 Sub: signed, wrap modulo 2^XLEN.
  - 3 Rshift: arithmetic right shift of srca.
  - 4 Lshift: left shift of srca.
  - 3 and 4 use only the low clog2(XLEN) bits of srcb as the shift amount.
  - 5 And, 6 Or, 7 Xor: bitwise.
  - 8 Div: signed quotient, truncates toward zero.
  - 9 Fadd, 10 Fsub, 11 Fmul, 12 Fdiv, 13 Fsqrt, 14 Ftoi, 15 Itof: FPU ops.
- Reset (rstn=0 at posedge):
  - pc_out=0; inst_out=all lanes Nop encoding (opcode Nop, remaining bits 0).
  - rt_flag_out=0, fpu_valid=0, tdata=0, rt_out=0.
  - Divider FSM to IDLE; done_mask=0; qreg=0.
  - Reset mid-divide aborts the divide silently.
- Commit: a posedge with rstn=1, interlock=0 and exec_stall=0 registers the bundle. Latency is 1 cycle.
  - tdata[i] = ALU(lane i); for Div lanes tdata[i] = qreg[i].
  - FPU lanes: fpu_valid[i]=1, fpu_op, fpu_srca/srcb, fpu_rt registered. tdata is don't-care. rt_flag_out[i] = rt_flag[i].
  - Non-FPU lanes: fpu_valid[i]=0.
  - done_mask cleared on commit.
- Bubble: a posedge with rstn=1, interlock=0 and exec_stall=1 loads rt_flag_out=0, fpu_valid=0 and inst_out=Nop. pc_out and data are don't-care.
- interlock=1: all output registers hold. The divider FSM keeps running.
- div_mask[i] = (e_type[i]==8).
- exec_stall = |(div_mask & ~done_mask).
- Divider FSM (single shared unit):
  - IDLE: if exec_stall, select the lowest lane i with a pending divide and go to LOAD.
  - LOAD (1 cycle): latch |srca|, |srcb| and the result sign for lane i; count = XLEN.
  - RUN (XLEN cycles): restoring shift-subtract, 1 quotient bit per cycle.
  - FIN (1 cycle): apply sign, write qreg[i], set done_mask[i], then go to IDLE.
  - Stall per divide lane is exactly XLEN+3 cycles, 35 at XLEN=32. Multiple divide lanes are served sequentially in ascending lane order.
- Divide boundary cases:
  - srcb=0: quotient all-ones (-1).
  - srca=-2^(XLEN-1) with srcb=-1: quotient -2^(XLEN-1).
- The upstream stage must not change inputs while exec_stall=1. A changed bundle in that window is undefined.

Optional Feature:
- Macro EXEC_DIV_EN.
- Defined: divider FSM, qreg and done_mask are present as described above.
- Undefined: no divider logic. e_type 8 behaves as Nop (tdata=srcb) and exec_stall is tied to 0.

Test Plan:
- Reset: rstn=0 for 2 cycles with arbitrary inputs -> rt_flag_out=0, fpu_valid=0, pc_out=0, inst_out=Nop in all lanes.
- NLANES=2 ALU ops:
  - lane0 Add 0x7FFFFFFF+1 -> tdata0=0x80000000.
  - lane1 Rshift 0x80000000 by srcb=0x21 -> tdata1=0xC0000000 (shift amount 1).
  - Both results appear one cycle later.
- FPU dispatch: lane1 e_type=11 with rt=7 -> fpu_valid=2'b10, fpu_op[lane1]=2, fpu_rt[lane1]=7; lane0 fpu_valid=0.
- Divides (EXEC_DIV_EN):
  - lane0 -7/2 and lane1 100/0 -> exec_stall high 70 cycles, one bubble per cycle.
  - Commit then gives tdata0=0xFFFFFFFD and tdata1=0xFFFFFFFF.
- Interlock during divide: interlock=1 on cycles 10..50 of a single divide -> outputs hold throughout. Stall drops after 35 cycles; commit occurs on the first edge with interlock=0.
- Reset mid-divide: rstn=0 at cycle 20 of a divide -> FSM IDLE, done_mask=0. After reset with the same bundle, the divide restarts and stalls the full 35 cycles.
